rr_arbiter4: RTL and testbench

- Four-requester round-robin arbiter for one shared resource.
- Issues a registered 2-bit grant index plus valid, enforces a maximum hold time, and inserts a one-cycle turnaround gap between owners.
- A 2-to-4 decoder with enable expands the index into the one-hot grant bus that drives the resource-select lines.

---
 rtl/arb_pkg.sv | 32 +++
 rtl/dec2to4_en.sv | 19 +
 rtl/rr_arbiter4.sv | 95 +++++++++
 tb/tb_rr_arbiter4.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Holds state encodings, requester count and the rotating priority search.
package arb_pkg;

    localparam int NREQ  = 4;
    localparam int IDX_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        GAP  = 2'b10
    } state_e;

    // First set request bit found scanning ptr, ptr+1, ... modulo NREQ.
    // Scanning downward lets the closest candidate overwrite farther ones.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NREQ-1:0]  req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        pick = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = ptr + k[IDX_W-1:0];
            if (req[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/dec2to4_en.sv
// 2-to-4 one-hot decoder with enable.
// Drives the resource-select lines from the registered grant index.
module dec2to4_en
    import arb_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREQ-1:0]  onehot
);

    // Single bit set at idx when enabled, otherwise all zero.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold limit and turnaround gap.
// Grant index, valid and timeout are registered; gnt is decoded from them.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic             at_limit;
    logic             own_req;

    // Next-state: arbitrate in IDLE, count and release in BUSY, one idle beat in GAP.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        at_limit    = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
        own_req     = req[gnt_idx_q];
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_idx_d   = rr_pick(req, ptr_q);
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                if (done || !own_req || at_limit) begin
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + IDX_W'(1);
                    // Forced release only when the owner still wanted it.
                    timeout_d   = at_limit && !done && own_req;
                    state_d     = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset restarts priority at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

    dec2to4_en u_dec (
        .idx    (gnt_idx_q),
        .en     (gnt_valid_q),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4 against an ownership-level reference model.
// Driver pushes expected post-edge outputs; monitor pops and compares.
module tb_rr_arbiter4;

    localparam int MH = 8;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       v;
        logic       t;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    int m_owner;
    int m_held;
    bit m_gap;
    int m_last;
    int m_prio;
    bit m_tmo;

    rr_arbiter4 #(.MAX_HOLD(MH), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_last  = 0;
        m_prio  = 0;
        m_tmo   = 0;
        exp_q.delete();
    endtask

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, want);
        end
    endtask

    // Drive inputs for the coming edge and predict outputs after it.
    task automatic apply(input logic [3:0] r, input logic d);
        exp_t e;
        req  = r;
        done = d;
        m_tmo = 0;
        if (m_owner >= 0) begin
            if (d || !r[m_owner] || (m_held + 1 == MH)) begin
                m_tmo   = !d && r[m_owner] && (m_held + 1 == MH);
                m_prio  = (m_owner + 1) % 4;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (r != 0) begin
            for (int k = 3; k >= 0; k--) begin
                if (r[(m_prio + k) % 4]) m_owner = (m_prio + k) % 4;
            end
            m_last = m_owner;
            m_held = 0;
        end
        e.gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.idx = 2'(m_last);
        e.v   = (m_owner >= 0);
        e.t   = m_tmo;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] r, input logic d);
        @(negedge clk);
        apply(r, d);
    endtask

    // Monitor: compare the DUT against the oldest prediction after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt", {4'b0, gnt}, {4'b0, e.gnt});
                check("gnt_idx", {6'b0, gnt_idx}, {6'b0, e.idx});
                check("gnt_valid", {7'b0, gnt_valid}, {7'b0, e.v});
                check("timeout", {7'b0, timeout}, {7'b0, e.t});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic       d;
        n_vec = 0;
        n_err = 0;
        model_reset();

        // Reset with all requesting: outputs must be clear.
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        #1;
        check("rst_gnt", {4'b0, gnt}, 8'h00);
        check("rst_valid", {7'b0, gnt_valid}, 8'h00);
        check("rst_tmo", {7'b0, timeout}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt_clk", {4'b0, gnt}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1111, 1'b0);

        // Rotation: all requesting, done two cycles into each grant.
        repeat (30) begin
            step(4'b1111, (m_owner >= 0) && (m_held == 1));
        end

        // Sole requester hitting the hold limit, twice.
        repeat (24) step(4'b0100, 1'b0);

        // done coinciding with the hold limit.
        repeat (3) step(4'b0000, 1'b0);
        repeat (12) begin
            step(4'b1000, (m_owner >= 0) && (m_held == MH - 1));
        end

        // Owner 0 drops its request after three cycles.
        repeat (3) step(4'b0000, 1'b0);
        repeat (10) begin
            r = ((m_owner == 0) && (m_held >= 2)) ? 4'b0010 : 4'b0011;
            step(r, 1'b0);
        end

        // Wrap: grant 1 then only requester 0 asks.
        repeat (4) step(4'b0000, 1'b0);
        repeat (3) step(4'b0010, 1'b0);
        step(4'b0010, 1'b1);
        repeat (4) step(4'b0001, 1'b0);

        // Async reset while requester 3 owns the resource.
        repeat (4) step(4'b0000, 1'b0);
        repeat (3) step(4'b1000, 1'b0);
        @(posedge clk);
        #3;
        check("pre_rst_gnt", {4'b0, gnt}, 8'h08);
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        check("async_gnt", {4'b0, gnt}, 8'h00);
        check("async_valid", {7'b0, gnt_valid}, 8'h00);
        check("async_idx", {6'b0, gnt_idx}, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(4'b1001, 1'b0);
        repeat (4) step(4'b1001, 1'b0);

        // Randomized traffic with level-held requests.
        r = 4'b0000;
        repeat (600) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(3) == 0) r[i] = ~r[i];
            end
            d = ($urandom_range(5) == 0);
            step(r, d);
        end

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
